// File: rtl/fpga_clock_gate_ctrl.sv
// Multi-channel registered clock-enable controller (FREE/DIFF/STEP/HALT) with post-reset hold window and enabled-cycle counter.
// Latency: one cycle from inputs to ce_o/step_done_o/running_o; no backpressure, decisions are made every cycle.
// Optional CLKGATE_WATCHDOG_EN adds timeout_o, a sticky flag for data_next_i stalls in DIFF mode.
module fpga_clock_gate_ctrl #(
    parameter int NUM_CH   = 2,
    parameter int CNT_W    = 32,
    parameter int RST_HOLD = 16
`ifdef CLKGATE_WATCHDOG_EN
    ,
    parameter int WDOG_CYC = 1024
`endif
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [1:0]        mode_i,
    input  logic              data_next_i,
    input  logic [NUM_CH-1:0] ch_mask_i,
    input  logic [CNT_W-1:0]  step_cnt_i,
    input  logic              step_start_i,
`ifdef CLKGATE_WATCHDOG_EN
    output logic              timeout_o,
`endif
    output logic              step_done_o,
    output logic [NUM_CH-1:0] ce_o,
    output logic              running_o,
    output logic [CNT_W-1:0]  cycles_o
);

    localparam int HOLD_W = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
    localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(RST_HOLD - 1);

    localparam logic [1:0] M_FREE = 2'b00;
    localparam logic [1:0] M_DIFF = 2'b01;
    localparam logic [1:0] M_STEP = 2'b10;
    localparam logic [1:0] M_HALT = 2'b11;

    typedef enum logic [2:0] {
        S_HOLD,
        S_FREE,
        S_DIFF,
        S_STEP_IDLE,
        S_STEP_RUN,
        S_HALT
    } state_t;

    state_t              state_q, state_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic [CNT_W-1:0]    scnt_q, scnt_d;
    logic [NUM_CH-1:0]   ce_q, ce_d;
    logic                done_q, done_d;
    logic                run_q, run_d;
    logic [CNT_W-1:0]    cyc_q, cyc_d;
    logic                sample_mode;

    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        scnt_d      = scnt_q;
        ce_d        = ce_q;
        done_d      = 1'b0;
        sample_mode = 1'b0;

        case (state_q)
            S_HOLD: begin
                ce_d = '1;
                if (hold_q == '0) begin
                    sample_mode = 1'b1;
                end else begin
                    hold_d = hold_q - HOLD_W'(1);
                end
            end
            S_STEP_IDLE: begin
                if (mode_i == M_STEP) begin
                    ce_d = '0;
                    if (step_start_i) begin
                        if (step_cnt_i != '0) begin
                            state_d = S_STEP_RUN;
                            scnt_d  = step_cnt_i;
                            ce_d    = ch_mask_i;
                        end else begin
                            done_d = 1'b1;
                        end
                    end
                end else begin
                    sample_mode = 1'b1;
                end
            end
            S_STEP_RUN: begin
                // scnt_q counts enabled cycles still owed, including the current one
                if (mode_i == M_STEP) begin
                    if (scnt_q > CNT_W'(1)) begin
                        scnt_d = scnt_q - CNT_W'(1);
                        ce_d   = ch_mask_i;
                    end else begin
                        scnt_d  = '0;
                        ce_d    = '0;
                        done_d  = 1'b1;
                        state_d = S_STEP_IDLE;
                    end
                end else begin
                    sample_mode = 1'b1;
                end
            end
            default: sample_mode = 1'b1;
        endcase

        if (sample_mode) begin
            scnt_d = '0;
            case (mode_i)
                M_FREE: begin
                    state_d = S_FREE;
                    ce_d    = ch_mask_i;
                end
                M_DIFF: begin
                    state_d = S_DIFF;
                    ce_d    = ch_mask_i & {NUM_CH{data_next_i}};
                end
                M_STEP: begin
                    state_d = S_STEP_IDLE;
                    ce_d    = '0;
                end
                default: begin
                    state_d = S_HALT;
                    ce_d    = '0;
                end
            endcase
        end

        run_d = |ce_d;
        cyc_d = cyc_q + ((run_q && (state_q != S_HOLD)) ? CNT_W'(1) : CNT_W'(0));
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_HOLD;
            hold_q  <= HOLD_INIT;
            scnt_q  <= '0;
            ce_q    <= '1;
            done_q  <= 1'b0;
            run_q   <= 1'b1;
            cyc_q   <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            scnt_q  <= scnt_d;
            ce_q    <= ce_d;
            done_q  <= done_d;
            run_q   <= run_d;
            cyc_q   <= cyc_d;
        end
    end

    assign ce_o        = ce_q;
    assign step_done_o = done_q;
    assign running_o   = run_q;
    assign cycles_o    = cyc_q;

`ifdef CLKGATE_WATCHDOG_EN
    localparam int WD_W = $clog2(WDOG_CYC + 1);

    logic [WD_W-1:0] wcnt_q, wcnt_d;
    logic            to_q, to_d;
    logic            wd_active;

    // Counter saturates at WDOG_CYC; the flag is sticky until DIFF is left
    always_comb begin
        wd_active = sample_mode && (mode_i == M_DIFF);
        wcnt_d    = '0;
        to_d      = 1'b0;
        if (wd_active) begin
            to_d = to_q;
            if (!data_next_i) begin
                wcnt_d = (int'(wcnt_q) >= WDOG_CYC) ? wcnt_q : wcnt_q + WD_W'(1);
                if (int'(wcnt_q) + 1 >= WDOG_CYC) begin
                    to_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wcnt_q <= '0;
            to_q   <= 1'b0;
        end else begin
            wcnt_q <= wcnt_d;
            to_q   <= to_d;
        end
    end

    assign timeout_o = to_q;
`endif

endmodule

// File: tb/tb_fpga_clock_gate_ctrl.sv
// Directed plus randomized bench for fpga_clock_gate_ctrl against a cycle-level behavioural model.
module tb_fpga_clock_gate_ctrl;
    localparam int NUM_CH   = 2;
    localparam int CNT_W    = 8;
    localparam int RST_HOLD = 4;
    localparam int WDOG     = 8;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic [1:0]        mode_i;
    logic              data_next_i;
    logic [NUM_CH-1:0] ch_mask_i;
    logic [CNT_W-1:0]  step_cnt_i;
    logic              step_start_i;
    logic              step_done_o;
    logic [NUM_CH-1:0] ce_o;
    logic              running_o;
    logic [CNT_W-1:0]  cycles_o;
`ifdef CLKGATE_WATCHDOG_EN
    logic              timeout_o;
`endif

    fpga_clock_gate_ctrl #(
        .NUM_CH  (NUM_CH),
        .CNT_W   (CNT_W),
        .RST_HOLD(RST_HOLD)
`ifdef CLKGATE_WATCHDOG_EN
        ,
        .WDOG_CYC(WDOG)
`endif
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .mode_i      (mode_i),
        .data_next_i (data_next_i),
        .ch_mask_i   (ch_mask_i),
        .step_cnt_i  (step_cnt_i),
        .step_start_i(step_start_i),
`ifdef CLKGATE_WATCHDOG_EN
        .timeout_o   (timeout_o),
`endif
        .step_done_o (step_done_o),
        .ce_o        (ce_o),
        .running_o   (running_o),
        .cycles_o    (cycles_o)
    );

    always #5 clk_i = ~clk_i;

    int tests = 0;
    int fails = 0;

    // Reference model: remaining hold cycles, owed step cycles, pending done
    int                hold_left;
    int                step_left;
    bit                in_step;
    bit                owe_done;
    logic [NUM_CH-1:0] m_ce;
    bit                m_done;
    int                m_cycles;
    bit                m_to;
    int                low_run;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all();
        chk("ce_o", 32'(ce_o), 32'(m_ce));
        chk("running_o", 32'(running_o), 32'(m_ce != '0));
        chk("step_done_o", 32'(step_done_o), 32'(m_done));
        chk("cycles_o", 32'(cycles_o), 32'(m_cycles));
`ifdef CLKGATE_WATCHDOG_EN
        chk("timeout_o", 32'(timeout_o), 32'(m_to));
`endif
    endtask

    task automatic model_reset();
        hold_left = RST_HOLD;
        step_left = 0;
        in_step   = 0;
        owe_done  = 0;
        m_ce      = '1;
        m_done    = 0;
        m_cycles  = 0;
        m_to      = 0;
        low_run   = 0;
    endtask

    task automatic model_edge();
        if (hold_left == 0 && m_ce != '0) m_cycles = (m_cycles + 1) % (1 << CNT_W);
        m_done = 0;
        if (hold_left > 1) begin
            hold_left--;
            m_ce = '1;
        end else begin
            hold_left = 0;
            if (mode_i != 2'b10) begin
                in_step   = 0;
                step_left = 0;
                owe_done  = 0;
            end
            case (mode_i)
                2'b00: m_ce = ch_mask_i;
                2'b01: m_ce = ch_mask_i & {NUM_CH{data_next_i}};
                2'b11: m_ce = '0;
                default: begin
                    m_ce = '0;
                    if (!in_step) begin
                        in_step = 1;
                    end else if (step_left > 0) begin
                        m_ce = ch_mask_i;
                        step_left--;
                        if (step_left == 0) owe_done = 1;
                    end else if (owe_done) begin
                        m_done   = 1;
                        owe_done = 0;
                    end else if (step_start_i) begin
                        if (step_cnt_i == 0) begin
                            m_done = 1;
                        end else begin
                            m_ce      = ch_mask_i;
                            step_left = int'(step_cnt_i) - 1;
                            owe_done  = (step_left == 0);
                        end
                    end
                end
            endcase
            if (mode_i == 2'b01) begin
                if (data_next_i) low_run = 0;
                else low_run++;
                if (low_run >= WDOG) m_to = 1;
            end else begin
                low_run = 0;
                m_to    = 0;
            end
        end
    endtask

    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk_i);
            model_edge();
            #1;
            check_all();
        end
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        #1;
        model_reset();
        check_all();
        @(posedge clk_i);
        #1;
        check_all();
        rst_i = 1'b0;
    endtask

    initial begin
        rst_i        = 1'b0;
        mode_i       = 2'b11;
        data_next_i  = 1'b0;
        ch_mask_i    = 2'b11;
        step_cnt_i   = '0;
        step_start_i = 1'b0;
        #2;
        do_reset();
        cyc(6);

        mode_i = 2'b00; ch_mask_i = 2'b01;
        cyc(12);
        mode_i = 2'b11;
        cyc(3);

        mode_i = 2'b01; ch_mask_i = 2'b11;
        data_next_i = 1'b1; cyc(1);
        data_next_i = 1'b0; cyc(1);
        data_next_i = 1'b1; cyc(2);
        data_next_i = 1'b0; cyc(2);

        mode_i = 2'b10;
        cyc(1);
        step_cnt_i = 8'd5; step_start_i = 1'b1; cyc(1);
        step_start_i = 1'b0; cyc(2);
        step_start_i = 1'b1; cyc(1);
        step_start_i = 1'b0; cyc(5);
        step_cnt_i = 8'd0; step_start_i = 1'b1; cyc(1);
        step_start_i = 1'b0; cyc(2);

        step_cnt_i = 8'd100; step_start_i = 1'b1; cyc(1);
        step_start_i = 1'b0; cyc(19);
        mode_i = 2'b00; ch_mask_i = 2'b10;
        cyc(10);

        mode_i = 2'b01; data_next_i = 1'b0;
        cyc(10);
        data_next_i = 1'b1; cyc(3);
        mode_i = 2'b00; cyc(2);

        mode_i = 2'b10; cyc(1);
        step_cnt_i = 8'd7; step_start_i = 1'b1; cyc(1);
        step_start_i = 1'b0; cyc(2);
        do_reset();
        cyc(7);

        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 9) == 0) mode_i = 2'($urandom_range(0, 3));
            data_next_i  = ($urandom_range(0, 3) != 0);
            ch_mask_i    = 2'($urandom);
            step_start_i = ($urandom_range(0, 3) == 0);
            step_cnt_i   = 8'($urandom_range(0, 6));
            if ($urandom_range(0, 299) == 0) do_reset();
            cyc(1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
